// File: rtl/deframer_pkg.sv
// Shared types for the UART receive deframer: FSM state encoding, error codes
// and the default frame start marker.
package deframer_pkg;

    typedef enum logic [2:0] {
        StHunt,
        StLenHi,
        StLenLo,
        StPayload,
        StCsum
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/rdy_edge_sync.sv
// Input capture for the deframer: brings the asynchronous receiver ready level into
// the clk domain, detects its rising edge and registers the byte once per edge.
// byte_stb is a single-cycle pulse three clk edges after rx_rdy rises.
module rdy_edge_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       byte_stb,
    output logic [7:0] byte_data
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       stb_q;
    logic [7:0] data_q;
    logic       rise;

    assign rise = sync2_q & ~prev_q;

    // Two-flop synchronizer, edge history and data capture on a detected rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            stb_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            sync1_q <= rx_rdy;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stb_q   <= rise;
            // rx_data has been stable since before rx_rdy rose, so it is safe here.
            if (rise) begin
                data_q <= rx_data;
            end
        end
    end

    assign byte_stb  = stb_q;
    assign byte_data = data_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// Parses sync / 16-bit length / payload / checksum frames from the UART byte
// stream and writes the payload into the image buffer. Payload writes are
// speculative; only frame_done marks the buffer contents as good.
// Optional inter-byte timeout is enabled by defining DEFRAMER_TIMEOUT_EN.
module uart_rx_deframer
    import deframer_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 784,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
`ifdef DEFRAMER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic [ADDR_W:0]   frame_len,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam logic [15:0] MaxLen = 16'(MAX_LEN);

    logic              byte_stb;
    logic [7:0]        byte_data;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       len_full;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_w;
    logic [7:0]        sum_q, sum_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    err_code_e         err_code_q, err_code_d;

    rdy_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .byte_stb  (byte_stb),
        .byte_data (byte_data)
    );

    // Full length as it will be once the low byte lands this cycle.
    assign len_full = {len_q[15:8], byte_data};
    // Number of payload bytes written including the current one.
    assign count_w  = {1'b0, addr_q} + (ADDR_W + 1)'(1);

`ifdef DEFRAMER_TIMEOUT_EN
    // The strobe cycle and the registered error each take one cycle, so firing at
    // TIMEOUT_CYCLES-2 puts frame_err exactly TIMEOUT_CYCLES after byte_stb.
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 2);

    logic [31:0] tmo_q, tmo_d;
    logic        tmo_hit;

    assign tmo_hit = (state_q != StHunt) && !byte_stb && (tmo_q == TmoLast);

    // Inter-byte counter: cleared by any byte or while hunting, else counts up.
    always_comb begin
        tmo_d = tmo_q + 32'd1;
        if (byte_stb || state_q == StHunt) begin
            tmo_d = 32'd0;
        end
    end

    // Inter-byte counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Frame parser: next state, length/address/checksum tracking and outputs.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_len_d = frame_len_q;
        err_code_d  = err_code_q;

        if (byte_stb) begin
            unique case (state_q)
                StHunt: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d = StLenHi;
                    end
                end
                StLenHi: begin
                    len_d[15:8] = byte_data;
                    state_d     = StLenLo;
                end
                StLenLo: begin
                    len_d = len_full;
                    if (len_full == 16'd0 || len_full > MaxLen) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = StHunt;
                    end else begin
                        addr_d  = '0;
                        sum_d   = 8'h00;
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = byte_data;
                    addr_d    = addr_q + ADDR_W'(1);
                    sum_d     = sum_q + byte_data;
                    if (count_w == len_q[ADDR_W:0]) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (byte_data == sum_q) begin
                        done_d      = 1'b1;
                        frame_len_d = len_q[ADDR_W:0];
                        err_code_d  = ERR_NONE;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = StHunt;
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end
`ifdef DEFRAMER_TIMEOUT_EN
        else if (tmo_hit) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = StHunt;
        end
`endif
    end

    // State and output registers; reset clears everything, including mid-frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            len_q       <= 16'h0000;
            addr_q      <= '0;
            sum_q       <= 8'h00;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_len_q <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_len_q <= frame_len_d;
            err_code_q  <= err_code_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_len  = frame_len_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != StHunt);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: table-driven frames, hand-written
// corner sequences and random frames scored against a frame-level model.
module tb_uart_rx_deframer;

    localparam int unsigned MaxLen = 784;
    localparam int unsigned AddrW  = 10;
    localparam int          StbLat = 4;  // rx_rdy rise to registered output

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             rx_rdy  = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             wr_en;
    logic [AddrW-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             frame_done;
    logic [AddrW:0]   frame_len;
    logic             frame_err;
    logic [1:0]       err_code;
    logic             busy;

`ifdef DEFRAMER_TIMEOUT_EN
    localparam int unsigned TmoCycles = 100;
    uart_rx_deframer #(
        .MAX_LEN        (MaxLen),
        .ADDR_W         (AddrW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TmoCycles)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );
`else
    uart_rx_deframer #(
        .MAX_LEN   (MaxLen),
        .ADDR_W    (AddrW),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        bit done;
        bit err;
        int code;
        int len;
        int cyc;
    } ev_t;

    typedef struct packed {
        logic [63:0] bytes;  // first byte in the top lane
        int          n;
        int          nwr;
        logic [23:0] wdat;   // expected write data, addr 0 in the top lane
        bit          done;
        bit          err;
        int          code;
        int          len;
    } vec_t;

    wr_t        obs_wr[$];
    ev_t        obs_ev[$];
    wr_t        exp_wr[$];
    ev_t        exp_ev[$];
    logic [7:0] tx[$];
    int         wr_rd = 0;
    int         ev_rd = 0;
    int         last_rise = 0;
    int         last_code = 0;
    int         last_len = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    vec_t       vecs[6];

    // Passive monitor: record every write and every frame event.
    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (wr_en) begin
            w.addr = int'(wr_addr);
            w.data = int'(wr_data);
            obs_wr.push_back(w);
        end
        if (frame_done || frame_err) begin
            e.done = frame_done;
            e.err  = frame_err;
            e.code = int'(err_code);
            e.len  = int'(frame_len);
            e.cyc  = cyc;
            obs_ev.push_back(e);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic exp_write(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic exp_done(input int l);
        ev_t e;
        e.done = 1'b1; e.err = 1'b0; e.code = 0; e.len = l; e.cyc = 0;
        exp_ev.push_back(e);
        last_code = 0;
        last_len  = l;
    endtask

    task automatic exp_error(input int c);
        ev_t e;
        e.done = 1'b0; e.err = 1'b1; e.code = c; e.len = last_len; e.cyc = 0;
        exp_ev.push_back(e);
        last_code = c;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data   = b;
        rx_rdy    = 1'b1;
        last_rise = cyc;
        repeat (hold) @(negedge clk);
        rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_tx(input int hold);
        logic [7:0] b;
        while (tx.size() > 0) begin
            b = tx.pop_front();
            send_byte(b, hold);
        end
        repeat (4) @(negedge clk);
    endtask

    // Builds one frame after optional garbage and records what the buffer and
    // controller should see, straight from the framing rules.
    task automatic model_frame(input int ngarb, input int len, input bit bad_sum);
        logic [7:0] b;
        int         sum;
        for (int i = 0; i < ngarb; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            tx.push_back(b);
        end
        tx.push_back(8'hA5);
        tx.push_back(8'(len / 256));
        tx.push_back(8'(len % 256));
        if (len == 0 || len > int'(MaxLen)) begin
            exp_error(1);
        end else begin
            sum = 0;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                tx.push_back(b);
                exp_write(i, int'(b));
                sum += int'(b);
            end
            if (bad_sum) begin
                tx.push_back(8'((sum + int'($urandom_range(1, 255))) % 256));
                exp_error(2);
            end else begin
                tx.push_back(8'(sum % 256));
                exp_done(len);
            end
        end
    endtask

    task automatic check_frame(input string name, input int lat, input bit exp_busy);
        int nw;
        int ne;
        nw = obs_wr.size() - wr_rd;
        ne = obs_ev.size() - ev_rd;
        chk({name, " write count"}, nw, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < nw; i++) begin
            chk($sformatf("%s wr_addr[%0d]", name, i), obs_wr[wr_rd + i].addr, exp_wr[i].addr);
            chk($sformatf("%s wr_data[%0d]", name, i), obs_wr[wr_rd + i].data, exp_wr[i].data);
        end
        chk({name, " event count"}, ne, exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < ne; i++) begin
            chk($sformatf("%s frame_done[%0d]", name, i), int'(obs_ev[ev_rd + i].done),
                int'(exp_ev[i].done));
            chk($sformatf("%s frame_err[%0d]", name, i), int'(obs_ev[ev_rd + i].err),
                int'(exp_ev[i].err));
            chk($sformatf("%s err_code[%0d]", name, i), obs_ev[ev_rd + i].code, exp_ev[i].code);
            chk($sformatf("%s frame_len[%0d]", name, i), obs_ev[ev_rd + i].len, exp_ev[i].len);
        end
        if (lat >= 0 && ne > 0) begin
            chk({name, " latency"}, obs_ev[obs_ev.size() - 1].cyc - last_rise, lat);
        end
        chk({name, " err_code hold"}, int'(err_code), last_code);
        chk({name, " frame_len hold"}, int'(frame_len), last_len);
        chk({name, " busy"}, int'(busy), int'(exp_busy));
        wr_rd += nw;
        ev_rd += ne;
        exp_wr.delete();
        exp_ev.delete();
    endtask

    task automatic check_idle(input string name);
        chk({name, " wr_en"}, int'(wr_en), 0);
        chk({name, " wr_addr"}, int'(wr_addr), 0);
        chk({name, " wr_data"}, int'(wr_data), 0);
        chk({name, " frame_done"}, int'(frame_done), 0);
        chk({name, " frame_err"}, int'(frame_err), 0);
        chk({name, " frame_len"}, int'(frame_len), 0);
        chk({name, " err_code"}, int'(err_code), 0);
        chk({name, " busy"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{bytes: {8'hA5, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60, 8'h00},
                    n: 7, nwr: 3, wdat: 24'h102030, done: 1'b1, err: 1'b0, code: 0, len: 3};
        vecs[1] = '{bytes: {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h7F, 8'h7F, 8'h00},
                    n: 7, nwr: 1, wdat: 24'h7F0000, done: 1'b1, err: 1'b0, code: 0, len: 1};
        vecs[2] = '{bytes: {8'hA5, 8'h03, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 3, nwr: 0, wdat: 24'h000000, done: 1'b0, err: 1'b1, code: 1, len: 0};
        vecs[3] = '{bytes: {8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h4A, 8'h00, 8'h00},
                    n: 6, nwr: 2, wdat: 24'hA5A500, done: 1'b1, err: 1'b0, code: 0, len: 2};
        vecs[4] = '{bytes: {8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00},
                    n: 6, nwr: 2, wdat: 24'h010200, done: 1'b0, err: 1'b1, code: 2, len: 0};
        vecs[5] = '{bytes: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 3, nwr: 0, wdat: 24'h000000, done: 1'b0, err: 1'b1, code: 1, len: 0};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of fixed frames
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].n; j++) tx.push_back(vecs[v].bytes[63 - 8 * j -: 8]);
            for (int k = 0; k < vecs[v].nwr; k++) exp_write(k, int'(vecs[v].wdat[23 - 8 * k -: 8]));
            if (vecs[v].done) exp_done(vecs[v].len);
            if (vecs[v].err) exp_error(vecs[v].code);
            send_tx(2);
            check_frame($sformatf("vec%0d", v), StbLat, 1'b0);
        end

        // Long rx_rdy level: one byte per rise only
        tx = '{8'hA5, 8'h00, 8'h01, 8'h33, 8'h33};
        exp_write(0, 8'h33);
        exp_done(1);
        send_tx(1000);
        check_frame("long_hold", StbLat, 1'b0);

        // Reset in the middle of the payload
        tx = '{8'hA5, 8'h00, 8'h05, 8'h11, 8'h22};
        exp_write(0, 8'h11);
        exp_write(1, 8'h22);
        send_tx(2);
        check_frame("mid_payload", -1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        rst_n     = 1'b1;
        last_code = 0;
        last_len  = 0;
        tx = '{8'hA5, 8'h00, 8'h01, 8'h44, 8'h44};
        exp_write(0, 8'h44);
        exp_done(1);
        send_tx(2);
        check_frame("after_reset", StbLat, 1'b0);

`ifdef DEFRAMER_TIMEOUT_EN
        // Stalled frame times out TmoCycles after the last byte strobe
        tx = '{8'hA5, 8'h00};
        exp_error(3);
        send_tx(2);
        repeat (TmoCycles + 20) @(negedge clk);
        check_frame("timeout", 3 + int'(TmoCycles), 1'b0);
`else
        // Stalled frame waits indefinitely, then completes
        tx = '{8'hA5, 8'h00};
        send_tx(2);
        repeat (200) @(negedge clk);
        check_frame("stall", -1, 1'b1);
        tx = '{8'h01, 8'h55, 8'h55};
        exp_write(0, 8'h55);
        exp_done(1);
        send_tx(2);
        check_frame("stall_resume", StbLat, 1'b0);
`endif

        // Largest accepted frame
        model_frame(0, int'(MaxLen), 1'b0);
        send_tx(2);
        check_frame("max_len", StbLat, 1'b0);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) len = 0;
            else if (kind == 1) len = int'($urandom_range(MaxLen + 1, 65535));
            else len = int'($urandom_range(1, 24));
            model_frame(int'($urandom_range(0, 3)), len, ($urandom_range(0, 3) == 0));
            send_tx(2);
            check_frame($sformatf("rand%0d", f), StbLat, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
